pokey_aud_dac_out: RTL
======================

Name: pokey_aud_dac_out

Overview:
- Consumer end of the per-channel 4-bit AUD outputs of the four POKEY audio channels.
- Sums the four channels, applies a click-free soft-mute gain ramp, and drives a 1-bit first-order delta-sigma stream for an external RC filter.
- Sits between the audio channel cores and the FPGA audio pin.
- Also exports the registered mixed sample for digital consumers.

Parameters:
- RAMP_DIV, 64, number of enn ticks between gain steps during a mute or unmute ramp (1..65535).
- GAIN_MAX, 8, full-scale gain code; the scaled sample is (sum*gain)>>3.

Ports:
- clk  input  1  system clock; all state updates on negedge clk.
- nRst  input  1  asynchronous active-low reset.
- enn  input  1  POKEY clock-enable tick; the sample path updates only when enn=1.
- AUD1  input  4  channel 1 level.
- AUD2  input  4  channel 2 level.
- AUD3  input  4  channel 3 level.
- AUD4  input  4  channel 4 level.
- chMask  input  4  per-channel enable; bit n=0 forces channel n+1 to zero in the sum.
- muteReq  input  1  level request; 1 requests the muted state.
- mixOut  output  6  registered scaled mix, range 0..60.
- dsOut  output  1  delta-sigma bit stream.
- muted  output  1  1 only when the MUTED state is reached (gain=0).
- rampBusy  output  1  1 while in RAMP_DOWN or RAMP_UP.

Behaviour:
- Reset (nRst=0, async): mixOut=0, dsOut=0, accumulator=0, gain=GAIN_MAX, state=UNMUTED, muted=0, rampBusy=0, ramp counter=0.
- Sum stage (enn=1):
  - sumReg <= masked AUD1+AUD2+AUD3+AUD4.
  - Width is 6 bits, maximum 60, so no overflow is possible.
- Scale stage (enn=1):
  - mixOut <= (sumReg*gain)>>3, computed with a 10-bit product and truncated.
  - AUD-to-mixOut latency is 2 enn ticks.
  - With gain=8, mixOut equals the sum exactly.
- Delta-sigma runs every negedge clk, independent of enn:
  - acc7 = {1'b0, acc[5:0]} + mixOut.
  - dsOut <= acc7[6]; acc <= acc7[5:0].
  - Ones density equals mixOut/64. mixOut=0 gives constant 0. Full scale 60 gives a 60/64 density.
- Soft-mute FSM, advanced on enn ticks only:
  - UNMUTED: gain=GAIN_MAX. muteReq=1 -> RAMP_DOWN, ramp counter cleared.
  - RAMP_DOWN: counter increments each enn tick. When counter=RAMP_DIV-1, gain decrements by 1 and the counter clears. When gain reaches 0 -> MUTED. If muteReq drops mid-ramp -> RAMP_UP from the current gain, counter cleared.
  - MUTED: gain=0, muted=1. muteReq=0 -> RAMP_UP.
  - RAMP_UP: mirror of RAMP_DOWN, gain increments; at GAIN_MAX -> UNMUTED. muteReq=1 mid-ramp -> RAMP_DOWN from the current gain.
  - A full ramp takes GAIN_MAX*RAMP_DIV enn ticks.
  - gain saturates at 0 and GAIN_MAX and never wraps.
- Simultaneous events:
  - A chMask change and a gain step in the same tick both take effect: the new mask goes into sumReg and the new gain is applied from the next tick.
  - muteReq toggling on a tick where a gain step also occurs: the step completes first, then the state changes.
- Reset asserted mid-ramp: immediate return to UNMUTED with full gain and accumulator cleared; no partial ramp resumes.
- enn held low: sumReg, mixOut and the FSM freeze; dsOut keeps modulating the held mixOut.

Decomposition:
- Shared package pokey_aud_pkg holds:
  - the state enum (UNMUTED, RAMP_DOWN, MUTED, RAMP_UP);
  - constants AUD_W=4, MIX_W=6, GAIN_W=4.
- One natural sub-module: aud_ds_mod, the 6-bit-in first-order delta-sigma modulator with its own async reset. It is reusable for other DAC pins.

Test Plan:
- Reset check: assert nRst=0 mid-stream -> all outputs 0 and state UNMUTED immediately. After release, AUD1..4=15, chMask=F, enn every cycle -> mixOut=60 on the 2nd enn tick.
- Masking: AUD1..4=4,5,6,7 with chMask=4'b0101 -> mixOut=10. With chMask=0 -> mixOut=0 and dsOut constant 0.
- Delta-sigma density: mixOut held at 16 -> exactly 16 ones in every 64-clk window after accumulator reset. mixOut=60 -> 60 ones per 64.
- Full mute ramp: RAMP_DIV=4, mix=60, assert muteReq:
  - gain steps 8..0 every 4 enn ticks;
  - mixOut sequence 52, 45, 37, 30, 22, 15, 7, 0;
  - muted=1 after 32 ticks; rampBusy=1 throughout.
- Reversal: drop muteReq when gain=5 in RAMP_DOWN -> RAMP_UP; gain 6, 7, 8 at 4-tick intervals; UNMUTED, rampBusy=0.
- enn gating: hold enn=0 for 100 clks while changing AUD -> mixOut and FSM unchanged; dsOut still toggles per the held value.

Source files
------------

// File: rtl/pokey_aud_pkg.sv
// Shared types and widths for the POKEY audio DAC output path.
// Holds the soft-mute state enum and sample/gain widths.
package pokey_aud_pkg;

  localparam int AUD_W  = 4;
  localparam int MIX_W  = 6;
  localparam int GAIN_W = 4;

  typedef enum logic [1:0] {
    UNMUTED,
    RAMP_DOWN,
    MUTED,
    RAMP_UP
  } mute_state_e;

endpackage

// File: rtl/pokey_aud_dac_out_if.sv
// Channel-level bundle between the POKEY audio cores and the DAC output.
// master: drives enn, AUD1..4, chMask, muteReq; slave: drives mix/ds/status.
interface pokey_aud_dac_out_if;
  import pokey_aud_pkg::*;

  logic             enn;
  logic [AUD_W-1:0] AUD1;
  logic [AUD_W-1:0] AUD2;
  logic [AUD_W-1:0] AUD3;
  logic [AUD_W-1:0] AUD4;
  logic [3:0]       chMask;
  logic             muteReq;
  logic [MIX_W-1:0] mixOut;
  logic             dsOut;
  logic             muted;
  logic             rampBusy;

  modport master (
    output enn, AUD1, AUD2, AUD3, AUD4,
    output chMask, muteReq,
    input  mixOut, dsOut, muted, rampBusy
  );

  modport slave (
    input  enn, AUD1, AUD2, AUD3, AUD4,
    input  chMask, muteReq,
    output mixOut, dsOut, muted, rampBusy
  );

endinterface

// File: rtl/aud_ds_mod.sv
// First-order 1-bit delta-sigma modulator, 6-bit unsigned input.
// Ports: clk (negedge), nRst (async low), din sample, dout bit stream.
module aud_ds_mod
  import pokey_aud_pkg::*;
(
  input  logic             clk,
  input  logic             nRst,
  input  logic [MIX_W-1:0] din,
  output logic             dout
);

  logic [MIX_W-1:0] acc_q, acc_d;
  logic             dout_q, dout_d;
  logic [MIX_W:0]   acc7;

  // Carry out of the 6-bit accumulator is the output bit,
  // giving a ones density of din/64.
  always_comb begin
    acc7   = {1'b0, acc_q} + {1'b0, din};
    acc_d  = acc7[MIX_W-1:0];
    dout_d = acc7[MIX_W];
  end

  always_ff @(negedge clk or negedge nRst) begin
    if (!nRst) begin
      acc_q  <= '0;
      dout_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/pokey_aud_dac_out.sv
// POKEY 4-channel mixer with soft-mute gain ramp and delta-sigma pin.
// Ports: clk (negedge), nRst (async low), bus (slave side of the bundle).
module pokey_aud_dac_out
  import pokey_aud_pkg::*;
#(
  parameter int RAMP_DIV = 64,
  parameter int GAIN_MAX = 8
) (
  input  logic                clk,
  input  logic                nRst,
  pokey_aud_dac_out_if.slave  bus
);

  localparam int CNT_W = 16;
  localparam logic [GAIN_W-1:0] G_MAX =
    GAIN_W'(GAIN_MAX);
  localparam logic [CNT_W-1:0] C_LAST =
    CNT_W'(RAMP_DIV - 1);

  mute_state_e       state_q, state_d;
  logic [GAIN_W-1:0] gain_q, gain_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [MIX_W-1:0]  sum_q, sum_d;
  logic [MIX_W-1:0]  mix_q, mix_d;
  logic              muted_q, muted_d;
  logic              busy_q, busy_d;

  logic [MIX_W-1:0]  a1, a2, a3, a4;
  logic [9:0]        prod;
  logic              step;

  assign a1 = bus.chMask[0] ? MIX_W'(bus.AUD1) : '0;
  assign a2 = bus.chMask[1] ? MIX_W'(bus.AUD2) : '0;
  assign a3 = bus.chMask[2] ? MIX_W'(bus.AUD3) : '0;
  assign a4 = bus.chMask[3] ? MIX_W'(bus.AUD4) : '0;

  assign prod = 10'(sum_q) * 10'(gain_q);
  assign step = (cnt_q == C_LAST);

  always_comb begin
    sum_d = sum_q;
    mix_d = mix_q;
    if (bus.enn) begin
      sum_d = a1 + a2 + a3 + a4;
      mix_d = MIX_W'(prod >> 3);
    end
  end

  // Gain steps land before a muteReq-driven direction change
  // evaluated on the same tick.
  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    cnt_d   = cnt_q;
    if (bus.enn) begin
      unique case (state_q)
        UNMUTED: begin
          gain_d = G_MAX;
          if (bus.muteReq) begin
            state_d = RAMP_DOWN;
            cnt_d   = '0;
          end
        end
        RAMP_DOWN: begin
          if (step) begin
            cnt_d  = '0;
            gain_d = (gain_q != '0) ?
                     gain_q - 1'b1 : '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
          if (!bus.muteReq) begin
            state_d = RAMP_UP;
            cnt_d   = '0;
          end else if (gain_d == '0) begin
            state_d = MUTED;
          end
        end
        MUTED: begin
          gain_d = '0;
          if (!bus.muteReq) begin
            state_d = RAMP_UP;
            cnt_d   = '0;
          end
        end
        RAMP_UP: begin
          if (step) begin
            cnt_d  = '0;
            gain_d = (gain_q < G_MAX) ?
                     gain_q + 1'b1 : G_MAX;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
          if (bus.muteReq) begin
            state_d = RAMP_DOWN;
            cnt_d   = '0;
          end else if (gain_d == G_MAX) begin
            state_d = UNMUTED;
          end
        end
        default: begin
          state_d = UNMUTED;
          gain_d  = G_MAX;
          cnt_d   = '0;
        end
      endcase
    end
    muted_d = (state_d == MUTED);
    busy_d  = (state_d == RAMP_DOWN) ||
              (state_d == RAMP_UP);
  end

  always_ff @(negedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= UNMUTED;
      gain_q  <= G_MAX;
      cnt_q   <= '0;
      sum_q   <= '0;
      mix_q   <= '0;
      muted_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gain_q  <= gain_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      mix_q   <= mix_d;
      muted_q <= muted_d;
      busy_q  <= busy_d;
    end
  end

  aud_ds_mod u_ds (
    .clk  (clk),
    .nRst (nRst),
    .din  (mix_q),
    .dout (bus.dsOut)
  );

  assign bus.mixOut   = mix_q;
  assign bus.muted    = muted_q;
  assign bus.rampBusy = busy_q;

endmodule
